// File: rtl/spi_pkg.sv
// Shared constants and helpers for the SPI word slave.
//   MODE0..MODE3 : SPI mode encodings as {CPOL, CPHA}
//   frame_state_e: frame sequencer states
//   clog2()      : ceiling log2, used to size the bit counter
package spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } frame_state_e;

  // Smallest r with 2**r >= value. The loop stops at 30 so that 1<<i never
  // goes negative.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin, with registered
// rise/fall pulses. Everything advances only in ce cycles.
//   clk, reset : system clock, synchronous active-high reset
//   ce         : advance enable
//   d_i        : asynchronous pin
//   q_o        : synchronised level, time-aligned with rise_o/fall_o
//   rise_o     : one-ce-cycle pulse on a synchronised 0->1
//   fall_o     : one-ce-cycle pulse on a synchronised 1->0
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic       rise_q;
  logic       fall_q;
  logic [2:0] fill_q;

  // fill_q marks when prev_q holds a real pin sample instead of RST_VAL.
  // Until then no edges are reported. Otherwise a pin that already sits at
  // its non-idle level when reset is released would look like a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      fill_q <= '0;
    end else if (ce) begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fill_q <= {fill_q[1:0], 1'b1};
      rise_q <= fill_q[2] & sync_q & ~prev_q;
      fall_q <= fill_q[2] & ~sync_q & prev_q;
    end
  end

  assign q_o    = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave that moves whole WORD_W-bit words. It supports all four SPI
// modes and either bit order. There is one receive output register and one
// transmit holding register.
//   clk, reset, ce           : system clock, sync active-high reset, enable
//   sck, cs_n, mosi          : asynchronous SPI pins
//   miso, miso_oe            : serial out and its output enable
//   rx_data/rx_valid/rx_ready: received word handshake
//   tx_data/tx_valid/tx_ready: word to transmit handshake
//   overrun, underrun        : sticky status, cleared by clr_status
//   busy                     : frame active
//
// state     | meaning
// ST_IDLE   | no frame; waiting for a synchronised cs_n fall
// ST_ACTIVE | frame open; sampling/shifting on SCK edges
module spi_slave_word
  import spi_pkg::*;
#(
  parameter int               WORD_W    = 8,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] TX_IDLE  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              overrun,
  output logic              underrun,
  input  logic              clr_status,
  output logic              busy
);

  localparam int         CNT_W          = clog2(WORD_W + 1);
  localparam logic [1:0] MODE           = {CPOL, CPHA};
  localparam bit         SAMPLE_ON_RISE = (MODE == MODE0) || (MODE == MODE3);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_sync #(.RST_VAL(CPOL)) u_sync_sck (
    .clk(clk), .reset(reset), .ce(ce), .d_i(sck),
    .q_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .ce(ce), .d_i(cs_n),
    .q_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .ce(ce), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  // Only the edge pulses are used from sck/cs_n, and only the level from mosi.
  logic unused_sync;
  assign unused_sync = ^{sck_lvl, cs_lvl, mosi_rise, mosi_fall};

  logic sample_ev, shift_ev;
  assign sample_ev = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_ev  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

  function automatic logic head_bit(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? w[WORD_W-1] : w[0];
  endfunction

  function automatic logic [WORD_W-1:0] advance(input logic [WORD_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  frame_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] rx_sr_q, rx_sr_d;
  logic [WORD_W-1:0] tx_sr_q, tx_sr_d;
  logic              miso_q, miso_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;

  logic [WORD_W-1:0] rx_next;
  logic [WORD_W-1:0] load_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic              word_done, load_req, set_ovr, set_udr;

  assign rx_next = MSB_FIRST ? {rx_sr_q[WORD_W-2:0], mosi_s}
                             : {mosi_s, rx_sr_q[WORD_W-1:1]};
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    underrun_d  = underrun_q;
    load_word   = TX_IDLE;
    word_done   = 1'b0;
    load_req    = 1'b0;
    set_ovr     = 1'b0;
    set_udr     = 1'b0;

    if (ce) begin
      if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

      if (tx_valid && !hold_full_q) begin
        hold_d      = tx_data;
        hold_full_d = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            state_d  = ST_ACTIVE;
            cnt_d    = '0;
            load_req = 1'b1;
          end
        end
        ST_ACTIVE: begin
          // When cs_n rises and a sample edge arrives in the same cycle, the
          // frame end wins and the bit is dropped.
          if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
          end else if (sample_ev) begin
            rx_sr_d = rx_next;
            if (cnt_inc == CNT_W'(WORD_W)) begin
              cnt_d     = '0;
              word_done = 1'b1;
              load_req  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (shift_ev) begin
            miso_d  = head_bit(tx_sr_q);
            tx_sr_d = advance(tx_sr_q);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (word_done) begin
        rx_data_d  = rx_next;
        rx_valid_d = 1'b1;
        // No overrun if the pending word is being accepted in this same cycle.
        set_ovr    = rx_valid_q && !rx_ready;
      end

      if (load_req) begin
        if (hold_full_q) begin
          load_word   = hold_q;
          hold_full_d = 1'b0;
        end else begin
          load_word = TX_IDLE;
          set_udr   = 1'b1;
        end
        // In CPHA=0 the first bit must already be on miso before the first
        // SCK edge, so it goes out at frame start. After that the shift
        // register always holds the next bit at its head.
        if (!CPHA && state_q == ST_IDLE) begin
          miso_d  = head_bit(load_word);
          tx_sr_d = advance(load_word);
        end else begin
          tx_sr_d = load_word;
        end
      end

      overrun_d  = (overrun_q  & ~clr_status) | set_ovr;
      underrun_d = (underrun_q & ~clr_status) | set_udr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = (state_q == ST_ACTIVE);
  assign busy     = (state_q == ST_ACTIVE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;
  assign overrun  = overrun_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_word.sv
// Bench for spi_slave_word. It uses two instances: dut0 runs in mode 0,
// MSB first, with TX_IDLE=FF; dut1 runs in mode 3, LSB first, with
// TX_IDLE=00. A behavioural SPI master drives the pins. Received words go
// into a queue of expected values, and a negedge monitor pops that queue on
// every rx handshake.
module tb_spi_slave_word;

  localparam int HP = 12;  // SCK half period in clk cycles

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce, clr_status, ce_tog;
  logic       sck[2], cs_n[2], mosi[2], rx_ready[2], tx_valid[2];
  logic [7:0] tx_data[2];
  logic       miso[2], miso_oe[2], rx_valid[2], tx_ready[2];
  logic       overrun[2], underrun[2], busy[2];
  logic [7:0] rx_data[2];

  spi_slave_word #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                   .TX_IDLE(8'hFF)) u_dut0 (
    .clk(clk), .reset(reset), .ce(ce), .sck(sck[0]), .cs_n(cs_n[0]),
    .mosi(mosi[0]), .miso(miso[0]), .miso_oe(miso_oe[0]),
    .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .overrun(overrun[0]), .underrun(underrun[0]), .clr_status(clr_status),
    .busy(busy[0])
  );

  spi_slave_word #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                   .TX_IDLE(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .ce(ce), .sck(sck[1]), .cs_n(cs_n[1]),
    .mosi(mosi[1]), .miso(miso[1]), .miso_oe(miso_oe[1]),
    .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .overrun(overrun[1]), .underrun(underrun[1]), .clr_status(clr_status),
    .busy(busy[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] rxq0[$];
  logic [7:0] rxq1[$];
  logic [7:0] mw[$];
  bit         hold_full_m[2];
  logic [7:0] hold_m[2];
  bit         ovr_m[2];
  bit         udr_m[2];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] idle_of(input int d);
    return (d == 0) ? 8'hFF : 8'h00;
  endfunction

  task automatic push_rx(input int d, input logic [7:0] v);
    if (d == 0) rxq0.push_back(v);
    else        rxq1.push_back(v);
  endtask

  // A word is pulled into the shift register at frame start and after every
  // complete word: the pending tx word if there is one, else the idle word
  // plus underrun.
  task automatic model_load(input int d, output logic [7:0] w);
    if (hold_full_m[d]) begin
      w = hold_m[d];
      hold_full_m[d] = 1'b0;
    end else begin
      w = idle_of(d);
      udr_m[d] = 1'b1;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hp;
    repeat (HP) tick();
  endtask

  // ce generator: each value is set 3 time units after a posedge and is used
  // by the following posedge.
  always @(posedge clk) begin
    #3;
    ce = ce_tog ? ~ce : 1'b1;
  end

  // Scoreboard monitor. At the negedge, ce holds the value used by the coming
  // posedge, so a handshake that will happen at that edge is seen here.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset && ce && rx_valid[d] && rx_ready[d]) begin
        logic [7:0] e;
        bit have;
        have = 1'b0;
        e = 8'h00;
        if (d == 0 && rxq0.size() > 0) begin e = rxq0.pop_front(); have = 1'b1; end
        if (d == 1 && rxq1.size() > 0) begin e = rxq1.pop_front(); have = 1'b1; end
        if (!have) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected dut%0d: got %02h expected no word", d, rx_data[d]);
        end else begin
          check($sformatf("rx_data dut%0d", d), {24'h0, rx_data[d]}, {24'h0, e});
        end
      end
    end
  end

  task automatic push_tx(input int d, input logic [7:0] v);
    int n;
    check($sformatf("tx_ready_pre dut%0d", d), {31'h0, tx_ready[d]}, {31'h0, !hold_full_m[d]});
    tx_data[d]  = v;
    tx_valid[d] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ce && n < 20);
    tx_valid[d] = 1'b0;
    hold_full_m[d] = 1'b1;
    hold_m[d] = v;
    check($sformatf("tx_ready_post dut%0d", d), {31'h0, tx_ready[d]}, 32'h0);
  endtask

  task automatic do_clr;
    int n;
    clr_status = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ce && n < 20);
    clr_status = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ovr_m[d] = 1'b0;
      udr_m[d] = 1'b0;
    end
  endtask

  task automatic check_flags(input int d);
    check($sformatf("overrun dut%0d", d), {31'h0, overrun[d]}, {31'h0, ovr_m[d]});
    check($sformatf("underrun dut%0d", d), {31'h0, underrun[d]}, {31'h0, udr_m[d]});
  endtask

  task automatic check_idle(input int d);
    check($sformatf("rst rx_data dut%0d", d), {24'h0, rx_data[d]}, 32'h0);
    check($sformatf("rst rx_valid dut%0d", d), {31'h0, rx_valid[d]}, 32'h0);
    check($sformatf("rst tx_ready dut%0d", d), {31'h0, tx_ready[d]}, 32'h1);
    check($sformatf("rst miso dut%0d", d), {31'h0, miso[d]}, 32'h0);
    check($sformatf("rst miso_oe dut%0d", d), {31'h0, miso_oe[d]}, 32'h0);
    check($sformatf("rst busy dut%0d", d), {31'h0, busy[d]}, 32'h0);
    check($sformatf("rst overrun dut%0d", d), {31'h0, overrun[d]}, 32'h0);
    check($sformatf("rst underrun dut%0d", d), {31'h0, underrun[d]}, 32'h0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    check_idle(0);
    check_idle(1);
    reset = 1'b0;
    rxq0.delete();
    rxq1.delete();
    for (int d = 0; d < 2; d++) begin
      hold_full_m[d] = 1'b0;
      ovr_m[d] = 1'b0;
      udr_m[d] = 1'b0;
    end
  endtask

  // Behavioural master. It sends the words in mw; the final word carries
  // last_bits bits. It captures miso on every sample edge and compares each
  // complete word against the model's transmit word.
  task automatic xfer(input int d, input int last_bits, input bit raise_cs,
                      input bit chk_lat);
    bit cp, cpha, msb, b;
    int nb, pos;
    logic [7:0] w, got, exp_tx;
    cp   = (d == 1);
    cpha = (d == 1);
    msb  = (d == 0);
    cs_n[d] = 1'b0;
    model_load(d, exp_tx);
    wait_hp();
    check($sformatf("busy dut%0d", d), {31'h0, busy[d]}, 32'h1);
    check($sformatf("miso_oe dut%0d", d), {31'h0, miso_oe[d]}, 32'h1);
    for (int k = 0; k < mw.size(); k++) begin
      w  = mw[k];
      nb = (k == mw.size() - 1) ? last_bits : 8;
      if (nb == 8) push_rx(d, w);
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        pos = msb ? 7 - i : i;
        b   = w[pos];
        if (!cpha) begin
          mosi[d] = b;
          wait_hp();
          got[pos] = miso[d];
          sck[d] = ~cp;
          if (chk_lat && k == mw.size() - 1 && i == nb - 1) begin
            for (int j = 1; j <= 4; j++) begin
              tick();
              check($sformatf("latency_c%0d", j), {31'h0, rx_valid[d]}, {31'h0, (j == 4)});
            end
            repeat (HP - 4) tick();
          end else begin
            wait_hp();
          end
          sck[d] = cp;
        end else begin
          wait_hp();
          sck[d]  = ~cp;
          mosi[d] = b;
          wait_hp();
          got[pos] = miso[d];
          sck[d] = cp;
        end
      end
      if (nb == 8) begin
        check($sformatf("miso_word dut%0d w%0d", d, k), {24'h0, got}, {24'h0, exp_tx});
        model_load(d, exp_tx);
      end
    end
    wait_hp();
    if (raise_cs) begin
      cs_n[d] = 1'b1;
      wait_hp();
      check($sformatf("end busy dut%0d", d), {31'h0, busy[d]}, 32'h0);
      check($sformatf("end miso dut%0d", d), {31'h0, miso[d]}, 32'h0);
    end
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((rxq0.size() + rxq1.size()) > 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", rxq0.size() + rxq1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int d, nw;
    logic [7:0] v;
    reset = 1'b1; ce = 1'b1; ce_tog = 1'b0; clr_status = 1'b0;
    sck[0] = 1'b0; sck[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cs_n[i] = 1'b1; mosi[i] = 1'b0; rx_ready[i] = 1'b1;
      tx_valid[i] = 1'b0; tx_data[i] = 8'h00;
    end
    repeat (3) tick();
    do_reset();
    repeat (5) tick();

    // Mode 0: receive A5 while transmitting 3C, with a latency check
    push_tx(0, 8'h3C);
    mw = '{8'hA5};
    xfer(0, 8, 1'b1, 1'b1);
    drain();
    check_flags(0);

    // Mode 3, LSB first, three-word frame
    push_tx(1, 8'h5C);
    mw = '{8'h01, 8'h80, 8'hFF};
    xfer(1, 8, 1'b1, 1'b0);
    drain();
    check_flags(1);

    // Overrun: rx_ready held low for two words
    rx_ready[0] = 1'b0;
    mw = '{8'h11, 8'h22};
    xfer(0, 8, 1'b1, 1'b0);
    while (rxq0.size() > 1) void'(rxq0.pop_front());
    ovr_m[0] = 1'b1;
    check("ovr rx_data", {24'h0, rx_data[0]}, 32'h22);
    check("ovr rx_valid", {31'h0, rx_valid[0]}, 32'h1);
    check_flags(0);
    rx_ready[0] = 1'b1;
    drain();
    do_clr();
    check_flags(0);

    // Underrun: no tx word, idle word FF goes out
    mw = '{8'h00};
    xfer(0, 8, 1'b1, 1'b0);
    drain();
    check_flags(0);
    check("udr tx_ready", {31'h0, tx_ready[0]}, 32'h1);

    // Partial frame dropped, then full 5A
    mw = '{8'h96};
    xfer(0, 5, 1'b1, 1'b0);
    check("partial rx_valid", {31'h0, rx_valid[0]}, 32'h0);
    mw = '{8'h5A};
    xfer(0, 8, 1'b1, 1'b0);
    drain();

    // Reset mid-frame with ce toggling; the still-open frame must be ignored
    ce_tog = 1'b1;
    mw = '{8'h3E};
    xfer(0, 4, 1'b0, 1'b0);
    do_reset();
    repeat (3) begin
      sck[0] = 1'b1; wait_hp();
      sck[0] = 1'b0; wait_hp();
    end
    check("ignored busy", {31'h0, busy[0]}, 32'h0);
    check("ignored rx_valid", {31'h0, rx_valid[0]}, 32'h0);
    cs_n[0] = 1'b1;
    wait_hp();
    push_tx(0, 8'h96);
    mw = '{8'hC3};
    xfer(0, 8, 1'b1, 1'b0);
    drain();
    check_flags(0);
    ce_tog = 1'b0;
    repeat (4) tick();

    // Randomised frames on both instances
    for (int it = 0; it < 8; it++) begin
      d  = $urandom_range(0, 1);
      nw = $urandom_range(1, 3);
      if (!hold_full_m[d] && $urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 255));
        push_tx(d, v);
      end
      mw.delete();
      for (int k = 0; k < nw; k++) mw.push_back(8'($urandom_range(0, 255)));
      xfer(d, 8, 1'b1, 1'b0);
      drain();
      check_flags(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_word.md
SPI_SLAVE_WORD -- requirements
Module: spi_slave_word

Interface
REQ-001 Parameter WORD_W, default 8, bits per SPI word (legal 4..32).
REQ-002 Parameter CPOL, default 0, SCK idle level.
REQ-003 Parameter CPHA, default 0; 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 Parameter MSB_FIRST, default 1; 1 = MSB shifted first, 0 = LSB first.
REQ-005 Parameter TX_IDLE, default all-zeros, word shifted out when no TX word is pending.
REQ-006 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port ce, input, 1, sample enable; logic advances only in cycles with ce=1 (tie high for full rate).
REQ-009 Port sck, cs_n, mosi, inputs, 1 each, asynchronous SPI pins; cs_n active-low.
REQ-010 Port miso, output, 1, serial data out; miso_oe, output, 1, high while frame active.
REQ-011 Port rx_data, output, WORD_W, last complete received word; rx_valid, output, 1; rx_ready, input, 1.
REQ-012 Port tx_data, input, WORD_W; tx_valid, input, 1; tx_ready, output, 1.
REQ-013 Port overrun, underrun, outputs, 1 each, sticky status; clr_status, input, 1, clears both.
REQ-014 Port busy, output, 1, high while frame active (synchronised cs_n low).

Function
REQ-015 sck, cs_n, mosi SHALL pass a 2-stage synchroniser clocked in ce cycles; edges are detected on synchronised values only.
REQ-016 Frame start = synchronised cs_n falling edge: bit counter cleared, TX shift register loaded (REQ-022), busy and miso_oe set.
REQ-017 Sample edge = rising if CPOL xor CPHA = 0, else falling; shift edge = opposite edge.
REQ-018 On each sample edge, mosi is shifted in (MSB_FIRST selects direction) and the bit counter increments.
REQ-019 When the counter reaches WORD_W, the word is copied to rx_data, rx_valid set on the next clk cycle, counter wraps to 0; multi-word frames continue without gaps.
REQ-020 rx_valid holds until a cycle with rx_ready=1 (cleared the following cycle); if a new word completes while rx_valid=1, rx_data is overwritten, rx_valid stays 1, overrun set.
REQ-021 tx_ready=1 when the one-word TX holding register is empty; tx_valid and tx_ready both high loads tx_data, tx_ready low the next cycle.
REQ-022 At frame start and at each word wrap, the shift register loads the holding word (holding emptied), or TX_IDLE plus underrun set if empty.
REQ-023 CPHA=0: first bit on miso at frame start, next bits on each shift edge; CPHA=1: every bit, first included, on shift edges.
REQ-024 Frame end (synchronised cs_n rising): partial word discarded, no rx_valid, counter cleared, busy and miso_oe low, miso 0; rx_valid and holding register unaffected.
REQ-025 Simultaneous cs_n rise and sample edge in the same cycle: frame end wins, bit ignored.
REQ-026 clr_status and a new overrun/underrun in the same cycle: flag SHALL end set.
REQ-027 Latency from last-bit sample edge on pins to rx_valid: exactly 4 ce cycles at ce=1 continuous (2 sync, 1 edge detect, 1 register).

Reset
REQ-028 reset=1 in any cycle (ignoring ce), including mid-frame, SHALL clear: rx_data=0, rx_valid=0, tx_ready=1, holding empty, miso=0, miso_oe=0, busy=0, overrun=0, underrun=0, counter=0, synchronisers to idle (sck=CPOL, cs_n=1).
REQ-029 A frame in progress at reset release is ignored until the next cs_n falling edge.

Structure
REQ-030 Package spi_pkg SHALL hold mode encoding constants (MODE0..MODE3 as CPOL/CPHA pairs) and the counter-width function clog2(WORD_W+1).
REQ-031 One sub-module spi_sync (2-flop synchroniser plus rise/fall pulse outputs, ce-qualified) SHALL be instantiated for sck and cs_n; mosi uses its data output only.

Verification
REQ-032 Mode 0, WORD_W=8, MSB first, master sends 0xA5 while tx holds 0x3C -> rx_data=0xA5, one rx_valid, miso carried 0x3C.
REQ-033 Mode 3, LSB first, 3-word frame 0x01,0x80,0xFF with rx_ready held high -> three rx_valid in order, overrun=0.
REQ-034 rx_ready held low, two words 0x11,0x22 -> rx_data=0x22, overrun=1; clr_status pulse -> overrun=0.
REQ-035 No tx_valid before frame, TX_IDLE=0xFF -> miso shifts 0xFF, underrun=1, tx_ready stays 1.
REQ-036 cs_n raised after 5 of 8 bits, then full frame 0x5A -> no rx_valid for partial, then rx_data=0x5A.
REQ-037 reset pulse after 4 bits, ce toggling 1/0 -> all outputs at REQ-028 values next cycle; following frame 0xC3 received correctly.
